// File: rtl/ibex_ex_issue_ctrl_if.sv
// rtl/ibex_ex_issue_ctrl_if.sv - ID/EX issue-control signal bundle with master (ID/EX side) and slave (controller) views
interface ibex_ex_issue_ctrl_if;
    logic                  instr_valid_i;
    logic                  instr_kill_i;
    logic                  mult_sel_i;
    logic                  div_sel_i;
    logic                  wb_ready_i;
    logic                  ex_valid_i;
    logic [1:0]            imd_val_we_i;
    logic [1:0][33:0]      imd_val_d_i;
    logic [1:0][33:0]      imd_val_q_o;
    logic                  mult_en_o;
    logic                  div_en_o;
    logic                  alu_instr_first_cycle_o;
    logic                  multdiv_ready_id_o;
    logic                  instr_done_o;
    logic                  stall_ex_o;
    logic                  perf_clr_i;
    logic [15:0]           perf_stall_cnt_o;

    modport master (
        output instr_valid_i, instr_kill_i, mult_sel_i, div_sel_i, wb_ready_i,
               ex_valid_i, imd_val_we_i, imd_val_d_i, perf_clr_i,
        input  imd_val_q_o, mult_en_o, div_en_o, alu_instr_first_cycle_o,
               multdiv_ready_id_o, instr_done_o, stall_ex_o, perf_stall_cnt_o
    );

    modport slave (
        input  instr_valid_i, instr_kill_i, mult_sel_i, div_sel_i, wb_ready_i,
               ex_valid_i, imd_val_we_i, imd_val_d_i, perf_clr_i,
        output imd_val_q_o, mult_en_o, div_en_o, alu_instr_first_cycle_o,
               multdiv_ready_id_o, instr_done_o, stall_ex_o, perf_stall_cnt_o
    );
endinterface

// File: rtl/ibex_ex_issue_ctrl.sv
// rtl/ibex_ex_issue_ctrl.sv - EX-stage issue control: first-cycle tracking, multdiv enables, imd registers, stall counter
module ibex_ex_issue_ctrl (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    ibex_ex_issue_ctrl_if.slave    bus
);

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_MULTI = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic             act;
    logic             done;
    logic             stall;
    logic [1:0][33:0] imd_val_q;
    logic [15:0]      stall_cnt_q;

    // A killed instruction behaves exactly like an absent one.
    assign act   = bus.instr_valid_i & ~bus.instr_kill_i;
    assign done  = act & bus.ex_valid_i & bus.wb_ready_i;
    assign stall = act & ~done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FIRST: begin
                if (act && !done) begin
                    state_d = ST_MULTI;
                end
            end
            ST_MULTI: begin
                if (done || !act) begin
                    state_d = ST_FIRST;
                end
            end
            default: state_d = ST_FIRST;
        endcase
    end

    assign bus.alu_instr_first_cycle_o = act & (state_q == ST_FIRST);
    assign bus.mult_en_o               = act & bus.mult_sel_i;
    assign bus.div_en_o                = act & bus.div_sel_i;
    assign bus.multdiv_ready_id_o      = bus.wb_ready_i;
    assign bus.instr_done_o            = done;
    assign bus.stall_ex_o              = stall;

    // Each intermediate entry has its own enable; both may update together.
    for (genvar k = 0; k < 2; k++) begin : g_imd
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                imd_val_q[k] <= 34'h0;
            end else if (bus.imd_val_we_i[k] && act) begin
                imd_val_q[k] <= bus.imd_val_d_i[k];
            end
        end
    end

    assign bus.imd_val_q_o = imd_val_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 16'h0;
        end else if (bus.perf_clr_i) begin
            stall_cnt_q <= 16'h0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h1;
        end
    end

    assign bus.perf_stall_cnt_o = stall_cnt_q;

    sel_exclusive_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.mult_sel_i && bus.div_sel_i));

endmodule

// File: tb/tb_ibex_ex_issue_ctrl.sv
// tb/tb_ibex_ex_issue_ctrl.sv - directed self-checking bench for ibex_ex_issue_ctrl
module tb_ibex_ex_issue_ctrl;

    logic clk_i;
    logic rst_ni;
    int   compared;
    int   mismatched;

    ibex_ex_issue_ctrl_if bus ();

    ibex_ex_issue_ctrl dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.instr_valid_i = 1'b0;
        bus.instr_kill_i  = 1'b0;
        bus.mult_sel_i    = 1'b0;
        bus.div_sel_i     = 1'b0;
        bus.wb_ready_i    = 1'b1;
        bus.ex_valid_i    = 1'b0;
        bus.imd_val_we_i  = 2'b00;
        bus.imd_val_d_i   = '0;
        bus.perf_clr_i    = 1'b0;
    endtask

    task automatic next();
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_ni     = 1'b0;
        idle();

        // Reset values; combinational outputs still follow inputs.
        #1;
        chk("rst_q0", bus.imd_val_q_o[0], 34'h0);
        chk("rst_q1", bus.imd_val_q_o[1], 34'h0);
        chk("rst_cnt", {18'h0, bus.perf_stall_cnt_o}, 34'h0);
        bus.instr_valid_i = 1'b1;
        bus.mult_sel_i    = 1'b1;
        #1;
        chk("rst_first", {33'h0, bus.alu_instr_first_cycle_o}, 34'h1);
        chk("rst_mult_en", {33'h0, bus.mult_en_o}, 34'h1);
        chk("rst_stall", {33'h0, bus.stall_ex_o}, 34'h1);
        @(posedge clk_i);
        #1;
        chk("rst_cnt_hold", {18'h0, bus.perf_stall_cnt_o}, 34'h0);
        @(negedge clk_i);
        idle();
        rst_ni = 1'b1;

        // Single-cycle ALU op
        next();
        bus.instr_valid_i = 1'b1;
        bus.ex_valid_i    = 1'b1;
        #1;
        chk("alu_done", {33'h0, bus.instr_done_o}, 34'h1);
        chk("alu_stall", {33'h0, bus.stall_ex_o}, 34'h0);
        chk("alu_first", {33'h0, bus.alu_instr_first_cycle_o}, 34'h1);
        chk("alu_ready", {33'h0, bus.multdiv_ready_id_o}, 34'h1);
        next();
        idle();
        chk("alu_cnt", {18'h0, bus.perf_stall_cnt_o}, 34'h0);

        // MUL over three EX cycles, then a back-to-back ALU op
        bus.instr_valid_i = 1'b1;
        bus.mult_sel_i    = 1'b1;
        #1;
        chk("mul_c1_first", {33'h0, bus.alu_instr_first_cycle_o}, 34'h1);
        chk("mul_c1_en", {33'h0, bus.mult_en_o}, 34'h1);
        chk("mul_c1_stall", {33'h0, bus.stall_ex_o}, 34'h1);
        chk("mul_c1_div_en", {33'h0, bus.div_en_o}, 34'h0);
        next();
        chk("mul_c2_first", {33'h0, bus.alu_instr_first_cycle_o}, 34'h0);
        chk("mul_c2_en", {33'h0, bus.mult_en_o}, 34'h1);
        chk("mul_c2_stall", {33'h0, bus.stall_ex_o}, 34'h1);
        next();
        bus.ex_valid_i = 1'b1;
        #1;
        chk("mul_c3_first", {33'h0, bus.alu_instr_first_cycle_o}, 34'h0);
        chk("mul_c3_en", {33'h0, bus.mult_en_o}, 34'h1);
        chk("mul_c3_done", {33'h0, bus.instr_done_o}, 34'h1);
        chk("mul_c3_stall", {33'h0, bus.stall_ex_o}, 34'h0);
        next();
        bus.mult_sel_i = 1'b0;
        #1;
        chk("mul_cnt", {18'h0, bus.perf_stall_cnt_o}, 34'h2);
        chk("b2b_first", {33'h0, bus.alu_instr_first_cycle_o}, 34'h1);
        chk("b2b_done", {33'h0, bus.instr_done_o}, 34'h1);

        // Intermediate writes: single entry, both entries, killed, no valid
        next();
        bus.imd_val_we_i   = 2'b10;
        bus.imd_val_d_i[1] = 34'h2_DEAD_BEEF;
        bus.imd_val_d_i[0] = 34'h1_2345_6789;
        next();
        chk("imd_w1_q1", bus.imd_val_q_o[1], 34'h2_DEAD_BEEF);
        chk("imd_w1_q0", bus.imd_val_q_o[0], 34'h0);
        bus.imd_val_we_i   = 2'b11;
        bus.imd_val_d_i[0] = 34'h0_1111_2222;
        bus.imd_val_d_i[1] = 34'h3_3333_4444;
        next();
        chk("imd_w2_q0", bus.imd_val_q_o[0], 34'h0_1111_2222);
        chk("imd_w2_q1", bus.imd_val_q_o[1], 34'h3_3333_4444);
        bus.instr_kill_i   = 1'b1;
        bus.mult_sel_i     = 1'b1;
        bus.imd_val_d_i[0] = 34'h3_FFFF_0000;
        bus.imd_val_d_i[1] = 34'h0_0000_FFFF;
        #1;
        chk("kill_done", {33'h0, bus.instr_done_o}, 34'h0);
        chk("kill_stall", {33'h0, bus.stall_ex_o}, 34'h0);
        chk("kill_mult_en", {33'h0, bus.mult_en_o}, 34'h0);
        next();
        chk("imd_kill_q0", bus.imd_val_q_o[0], 34'h0_1111_2222);
        chk("imd_kill_q1", bus.imd_val_q_o[1], 34'h3_3333_4444);
        bus.instr_kill_i  = 1'b0;
        bus.mult_sel_i    = 1'b0;
        bus.instr_valid_i = 1'b0;
        next();
        chk("imd_novalid_q0", bus.imd_val_q_o[0], 34'h0_1111_2222);
        idle();

        // DIV killed in its second cycle
        bus.instr_valid_i = 1'b1;
        bus.div_sel_i     = 1'b1;
        #1;
        chk("div_c1_en", {33'h0, bus.div_en_o}, 34'h1);
        chk("div_c1_first", {33'h0, bus.alu_instr_first_cycle_o}, 34'h1);
        next();
        bus.instr_kill_i = 1'b1;
        #1;
        chk("div_kill_en", {33'h0, bus.div_en_o}, 34'h0);
        chk("div_kill_stall", {33'h0, bus.stall_ex_o}, 34'h0);
        next();
        bus.instr_kill_i = 1'b0;
        bus.div_sel_i    = 1'b0;
        bus.ex_valid_i   = 1'b1;
        #1;
        chk("div_after_first", {33'h0, bus.alu_instr_first_cycle_o}, 34'h1);
        chk("div_cnt", {18'h0, bus.perf_stall_cnt_o}, 34'h3);

        // Result backpressure for four cycles
        next();
        bus.wb_ready_i = 1'b0;
        #1;
        chk("bp_c1_first", {33'h0, bus.alu_instr_first_cycle_o}, 34'h1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_stall", {33'h0, bus.stall_ex_o}, 34'h1);
            chk("bp_done", {33'h0, bus.instr_done_o}, 34'h0);
            chk("bp_ready", {33'h0, bus.multdiv_ready_id_o}, 34'h0);
            next();
        end
        bus.wb_ready_i = 1'b1;
        #1;
        chk("bp_c5_done", {33'h0, bus.instr_done_o}, 34'h1);
        chk("bp_c5_first", {33'h0, bus.alu_instr_first_cycle_o}, 34'h0);
        chk("bp_c5_ready", {33'h0, bus.multdiv_ready_id_o}, 34'h1);
        chk("bp_cnt", {18'h0, bus.perf_stall_cnt_o}, 34'h7);

        // Clear wins over a simultaneous stall increment
        next();
        bus.ex_valid_i = 1'b0;
        bus.perf_clr_i = 1'b1;
        next();
        bus.perf_clr_i = 1'b0;
        chk("clr_prio_cnt", {18'h0, bus.perf_stall_cnt_o}, 34'h0);

        // Counter saturation: stall up to FFFE, then three more cycles
        repeat (65534) @(negedge clk_i);
        #1;
        chk("cnt_fffe", {18'h0, bus.perf_stall_cnt_o}, 34'hFFFE);
        repeat (3) @(negedge clk_i);
        #1;
        chk("cnt_sat", {18'h0, bus.perf_stall_cnt_o}, 34'hFFFF);
        bus.perf_clr_i = 1'b1;
        next();
        bus.perf_clr_i = 1'b0;
        chk("cnt_clr", {18'h0, bus.perf_stall_cnt_o}, 34'h0);
        bus.instr_valid_i = 1'b0;

        // Asynchronous reset in the middle of a DIV with imd writes pending
        next();
        bus.instr_valid_i = 1'b1;
        bus.div_sel_i     = 1'b1;
        next();
        bus.imd_val_we_i   = 2'b11;
        bus.imd_val_d_i[0] = 34'h1_AAAA_5555;
        bus.imd_val_d_i[1] = 34'h2_5555_AAAA;
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_q0", bus.imd_val_q_o[0], 34'h0);
        chk("arst_q1", bus.imd_val_q_o[1], 34'h0);
        chk("arst_cnt", {18'h0, bus.perf_stall_cnt_o}, 34'h0);
        chk("arst_first", {33'h0, bus.alu_instr_first_cycle_o}, 34'h1);
        chk("arst_div_en", {33'h0, bus.div_en_o}, 34'h1);
        @(posedge clk_i);
        #1;
        chk("arst_q0_hold", bus.imd_val_q_o[0], 34'h0);
        @(negedge clk_i);
        idle();
        rst_ni = 1'b1;
        next();
        chk("post_rst_q1", bus.imd_val_q_o[1], 34'h0);
        bus.instr_valid_i = 1'b1;
        bus.ex_valid_i    = 1'b1;
        #1;
        chk("post_rst_first", {33'h0, bus.alu_instr_first_cycle_o}, 34'h1);
        next();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
